// File: rtl/kclique_pkg.sv
// Shared definitions for the k-clique search engine: FSM encodings,
// default sizing and a lowest-set-bit helper.
package kclique_pkg;

  localparam int N_DEF     = 8;
  localparam int K_MAX_DEF = 4;
  localparam int CNT_W_DEF = 16;

  localparam int VW = $clog2(N_DEF);
  localparam int KW = $clog2(K_MAX_DEF + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [4:0] lsb_index(input logic [31:0] mask);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kclique_search_engine_lsb_pick.sv
// Lowest-set-bit priority encoder: one-hot, binary index and non-empty flag.
module lsb_pick
  import kclique_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         mask,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // Isolate the lowest set bit with the two's-complement trick.
  assign onehot = mask & (~mask + {{(N-1){1'b0}}, 1'b1});
  assign index  = IDX_W'(lsb_index(32'(mask)));
  assign any    = |mask;

endmodule

// File: rtl/kclique_search_engine.sv
// Depth-first k-clique enumerator with candidate-set masks and a
// valid/ready clique stream plus a saturating clique counter.
module kclique_search_engine
  import kclique_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adj_wr_en,
  input  logic [$clog2(N)-1:0]         adj_wr_addr,
  input  logic [N-1:0]                 adj_wr_row,
  input  logic [N-1:0]                 vertex_en,
  input  logic [$clog2(K_MAX+1)-1:0]   k_sel,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         clique_valid,
  input  logic                         clique_ready,
  output logic [N-1:0]                 clique_mask,
  output logic [CNT_W-1:0]             num_cliques,
  output logic                         cnt_sat
);

  localparam int IDX_W = $clog2(N);
  localparam int DEP_W = $clog2(K_MAX + 1);

  logic [2:0]       state;
  logic [N-1:0]     adj    [N];
  logic [N-1:0]     eff    [N];
  logic [N-1:0]     cand   [K_MAX+1];
  logic [IDX_W-1:0] chosen [K_MAX];
  logic [DEP_W-1:0] depth;
  logic [DEP_W-1:0] k_q;
  logic [N-1:0]     ven_q;
  logic [N-1:0]     cur;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  logic             sat_q;

  logic [N-1:0]     cand_cur;
  logic [N-1:0]     cand_rest;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [DEP_W-1:0] depth_up;
  logic [DEP_W-1:0] depth_dn;
  logic             bad_k;

  // Effective edges need both directions and never include self-loops.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        eff[i][j] = adj[i][j] & adj[j][i] & (i != j);
      end
    end
  end

  assign cand_cur  = cand[depth];
  assign cand_rest = cand_cur & ~pick_oh;
  assign depth_up  = depth + DEP_W'(1);
  assign depth_dn  = depth - DEP_W'(1);
  assign bad_k     = (k_q == '0) || (int'(k_q) > K_MAX) || (int'(k_q) > N);

  lsb_pick #(.N(N)) u_pick (
    .mask   (cand_cur),
    .onehot (pick_oh),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Main control: row loading, search stepping, clique handshake and counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      depth <= '0;
      k_q   <= '0;
      ven_q <= '0;
      cur   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      sat_q <= 1'b0;
      for (int i = 0; i < N; i++) adj[i] <= '0;
      for (int i = 0; i <= K_MAX; i++) cand[i] <= '0;
      for (int i = 0; i < K_MAX; i++) chosen[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (adj_wr_en && (int'(adj_wr_addr) < N)) adj[adj_wr_addr] <= adj_wr_row;
          if (start) begin
            ven_q <= vertex_en;
            k_q   <= k_sel;
            cnt   <= '0;
            err_q <= 1'b0;
            sat_q <= 1'b0;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (bad_k) begin
            err_q <= 1'b1;
            state <= ST_DONE;
          end else begin
            cand[0] <= ven_q;
            depth   <= '0;
            cur     <= '0;
            state   <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (!pick_any) begin
            if (depth == '0) begin
              state <= ST_DONE;
            end else begin
              depth                 <= depth_dn;
              cur[chosen[depth_dn]] <= 1'b0;
            end
          end else begin
            cand[depth]    <= cand_rest;
            chosen[depth]  <= pick_idx;
            cur            <= cur | pick_oh;
            cand[depth_up] <= cand_rest & eff[pick_idx];
            depth          <= depth_up;
            if (depth_up == k_q) state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (abort) begin
            state <= ST_DONE;
          end else if (clique_ready) begin
            if (cnt == {CNT_W{1'b1}}) sat_q <= 1'b1;
            else                      cnt   <= cnt + CNT_W'(1);
            depth                 <= depth_dn;
            cur[chosen[depth_dn]] <= 1'b0;
            state                 <= ST_SEARCH;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state == ST_INIT) || (state == ST_SEARCH) || (state == ST_EMIT);
  assign done         = (state == ST_DONE);
  assign clique_valid = (state == ST_EMIT);
  assign clique_mask  = clique_valid ? cur : '0;
  assign num_cliques  = cnt;
  assign err          = err_q;
  assign cnt_sat      = sat_q;

endmodule

// File: tb/tb_kclique_search_engine.sv
// Scoreboard bench for the k-clique search engine: a brute-force model
// queues the expected cliques in emission order before each search.
module tb_kclique_search_engine;

  localparam int N     = 4;
  localparam int K_MAX = 4;
  localparam int VW    = $clog2(N);
  localparam int KW    = $clog2(K_MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          adj_wr_en = 1'b0;
  logic [VW-1:0] adj_wr_addr = '0;
  logic [N-1:0]  adj_wr_row = '0;
  logic [N-1:0]  vertex_en = '0;
  logic [KW-1:0] k_sel = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          clique_ready = 1'b0;

  logic          busy, done, err, clique_valid, cnt_sat;
  logic [N-1:0]  clique_mask;
  logic [15:0]   num_cliques;

  logic          s_busy, s_done, s_err, s_valid, s_sat;
  logic [N-1:0]  s_mask;
  logic [1:0]    s_num;

  int assertions = 0;
  int failures   = 0;

  logic [N-1:0] tb_adj [N];
  logic [N-1:0] exp_q [$];

  always #5 clk = ~clk;

  kclique_search_engine #(.N(N), .K_MAX(K_MAX), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .adj_wr_en(adj_wr_en), .adj_wr_addr(adj_wr_addr),
    .adj_wr_row(adj_wr_row), .vertex_en(vertex_en), .k_sel(k_sel), .start(start),
    .abort(abort), .busy(busy), .done(done), .err(err), .clique_valid(clique_valid),
    .clique_ready(clique_ready), .clique_mask(clique_mask), .num_cliques(num_cliques),
    .cnt_sat(cnt_sat)
  );

  kclique_search_engine #(.N(N), .K_MAX(K_MAX), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .adj_wr_en(adj_wr_en), .adj_wr_addr(adj_wr_addr),
    .adj_wr_row(adj_wr_row), .vertex_en(vertex_en), .k_sel(k_sel), .start(start),
    .abort(abort), .busy(s_busy), .done(s_done), .err(s_err), .clique_valid(s_valid),
    .clique_ready(clique_ready), .clique_mask(s_mask), .num_cliques(s_num),
    .cnt_sat(s_sat)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit isClique(input logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (m[i] && m[j] && (i != j) && !(tb_adj[i][j] && tb_adj[j][i])) return 1'b0;
    return 1'b1;
  endfunction

  // Walking the bit-reversed mask downward yields lexicographic order of sorted vertex lists.
  task automatic buildExpected(input int k, input logic [N-1:0] ven);
    exp_q.delete();
    for (int r = (1 << N) - 1; r >= 0; r--) begin
      logic [N-1:0] m;
      for (int b = 0; b < N; b++) m[b] = r[N-1-b];
      if ($countones(m) == k && (m & ~ven) == '0 && isClique(m)) exp_q.push_back(m);
    end
  endtask

  task automatic loadRow(input int idx, input logic [N-1:0] row);
    @(negedge clk);
    adj_wr_en   = 1'b1;
    adj_wr_addr = VW'(idx);
    adj_wr_row  = row;
    tb_adj[idx] = row;
    @(negedge clk);
    adj_wr_en = 1'b0;
  endtask

  task automatic loadK4();
    loadRow(0, 4'b1110);
    loadRow(1, 4'b1101);
    loadRow(2, 4'b1011);
    loadRow(3, 4'b1111);
  endtask

  task automatic applyStimulus(input int k, input logic [N-1:0] ven, input int stall,
                               input int abort_after, input bit exp_err);
    int  accepted;
    int  hold;
    int  abort_cyc;
    bit  finished;
    bit  aborted;
    accepted = 0; hold = 0; abort_cyc = 0; finished = 1'b0; aborted = 1'b0;
    if (exp_err) exp_q.delete();
    else         buildExpected(k, ven);
    @(negedge clk);
    k_sel        = KW'(k);
    vertex_en    = ven;
    start        = 1'b1;
    clique_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (done) begin
        finished = 1'b1;
        abort    = 1'b0;
        checkOutput("done_busy_low", 32'(busy), 32'd0);
        checkOutput("done_valid_low", 32'(clique_valid), 32'd0);
        checkOutput("count", 32'(num_cliques), 32'(accepted));
        checkOutput("err", 32'(err), 32'(exp_err));
        if (aborted) checkOutput("abort_latency", 32'(cyc), 32'(abort_cyc + 1));
        else         checkOutput("remaining_cliques", 32'(exp_q.size()), 32'd0);
      end else if (clique_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_clique", 32'(clique_mask), 32'd0);
          clique_ready = 1'b1;
        end else if (abort_after >= 0 && accepted == abort_after) begin
          abort        = 1'b1;
          clique_ready = 1'b0;
          aborted      = 1'b1;
          abort_cyc    = cyc;
        end else if (hold < stall) begin
          checkOutput("stall_hold", 32'(clique_mask), 32'(exp_q[0]));
          hold++;
          clique_ready = 1'b0;
        end else begin
          checkOutput("clique_mask", 32'(clique_mask), 32'(exp_q.pop_front()));
          accepted++;
          hold = 0;
          clique_ready = 1'b1;
        end
      end else begin
        clique_ready = (stall == 0);
      end
      @(negedge clk);
    end
    checkOutput("search_finished", 32'(finished), 32'd1);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    abort        = 1'b0;
    clique_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) tb_adj[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_valid", 32'(clique_valid), 32'd0);
    checkOutput("rst_mask", 32'(clique_mask), 32'd0);
    checkOutput("rst_count", 32'(num_cliques), 32'd0);
    checkOutput("rst_sat", 32'(cnt_sat), 32'd0);
    rst_n = 1'b1;

    $display("[TB] triangle with self-loop on vertex 0");
    loadRow(0, 4'b0111);
    loadRow(1, 4'b0101);
    loadRow(2, 4'b0011);
    applyStimulus(3, 4'b0111, 0, -1, 1'b0);

    $display("[TB] K4 triangles, ready high");
    loadK4();
    applyStimulus(3, 4'b1111, 0, -1, 1'b0);

    $display("[TB] K4 triangles, ready stalled");
    applyStimulus(3, 4'b1111, 5, -1, 1'b0);

    $display("[TB] K4 full clique at maximum depth");
    applyStimulus(4, 4'b1111, 0, -1, 1'b0);

    $display("[TB] k=1 singletons and counter saturation");
    applyStimulus(1, 4'b1111, 0, -1, 1'b0);
    checkOutput("sat_count", 32'(s_num), 32'd3);
    checkOutput("sat_flag", 32'(s_sat), 32'd1);
    checkOutput("wide_sat_flag", 32'(cnt_sat), 32'd0);

    $display("[TB] invalid k");
    applyStimulus(0, 4'b1111, 0, -1, 1'b1);
    applyStimulus(5, 4'b1111, 0, -1, 1'b1);

    $display("[TB] asymmetric edge ignored");
    loadRow(1, 4'b1100);
    applyStimulus(3, 4'b1111, 0, -1, 1'b0);
    applyStimulus(2, 4'b1011, 0, -1, 1'b0);

    $display("[TB] abort during second clique");
    loadK4();
    applyStimulus(3, 4'b1111, 0, 1, 1'b0);

    $display("[TB] no vertices enabled");
    applyStimulus(2, 4'b0000, 0, -1, 1'b0);

    $display("[TB] reset during search");
    @(negedge clk);
    k_sel = KW'(3); vertex_en = 4'b1111; start = 1'b1; clique_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(clique_valid), 32'd0);
    checkOutput("midrst_mask", 32'(clique_mask), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) tb_adj[i] = '0;
    applyStimulus(2, 4'b1111, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
